// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the SPI program-memory boot loader.
`timescale 1ns/1ps
package pm_loader_pkg;

    // Loader FSM states, in frame order
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR_L,
        ST_ADDR_H,
        ST_CNT_L,
        ST_CNT_H,
        ST_DAT_L,
        ST_DAT_H,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ldr_state_e;

    // Default frame header byte
    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // Minimum SPI clock high/low phase, in system clocks
    localparam int SCK_MIN_HALF = 2;

    // Running XOR fold used for the image checksum
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/pm_spi_loader_spi_byte_rx.sv
// SPI mode-0 slave byte receiver: synchronises sck/mosi/ss_n into clk,
// detects sck rising edges and ss_n edges, and assembles MSB-first bytes.
// byte_vld pulses for one clk on the 8th rising sck edge of a byte;
// byte_dat is valid in that same cycle.
`timescale 1ns/1ps
module spi_byte_rx #(
    parameter int SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       ireset,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_ss_n,
    output logic       byte_vld,
    output logic [7:0] byte_dat,
    output logic       ss_fall,
    output logic       ss_rise,
    output logic       ss_n_lvl
);
    import pm_loader_pkg::*;

    logic [SYNC_FF-1:0] sck_sync_q;
    logic [SYNC_FF-1:0] mosi_sync_q;
    logic [SYNC_FF-1:0] ss_sync_q;
    logic               sck_prev_q;
    logic               ss_prev_q;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         shift_q, shift_d;

    logic sck_s, mosi_s, ss_s;
    logic sck_rise, shift_en;

    // Synchroniser chains and edge-detect history; ss_n idles high
    always_ff @(posedge clk or negedge ireset) begin
        if (!ireset) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_FF-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_FF-2:0], spi_mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_FF-2:0], spi_ss_n};
            sck_prev_q  <= sck_sync_q[SYNC_FF-1];
            ss_prev_q   <= ss_sync_q[SYNC_FF-1];
        end
    end

    // Edge detection and byte assembly; mosi shares the sck latency so it
    // is sampled with the same alignment the master set it up with
    always_comb begin
        sck_s    = sck_sync_q[SYNC_FF-1];
        mosi_s   = mosi_sync_q[SYNC_FF-1];
        ss_s     = ss_sync_q[SYNC_FF-1];
        sck_rise = sck_s & ~sck_prev_q;
        ss_fall  = ~ss_s & ss_prev_q;
        ss_rise  = ss_s & ~ss_prev_q;
        ss_n_lvl = ss_s;
        shift_en = sck_rise & ~ss_s;
        byte_vld = shift_en & (bit_cnt_q == 3'd7);
        byte_dat = {shift_q, mosi_s};
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (ss_fall) begin
            bit_cnt_d = 3'd0;
        end else if (shift_en) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[5:0], mosi_s};
        end
    end

    // Bit counter and shift register state
    always_ff @(posedge clk or negedge ireset) begin
        if (!ireset) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/pm_spi_loader.sv
// SPI-slave boot loader feeding the Program_Mem write port. Parses
// HDR, ADDR_L, ADDR_H, CNT_L, CNT_H, {LO,HI} x CNT [, CHK], writes each
// 16-bit word and keeps the core in reset until a frame completes.
// Build option: define PM_LOADER_CHKSUM_EN to require a trailing XOR
// checksum byte over all data bytes.
`timescale 1ns/1ps
module pm_spi_loader
    import pm_loader_pkg::*;
#(
    parameter int         PM_AW    = 14,
    parameter int         SYNC_FF  = 2,
    parameter logic [7:0] HDR_BYTE = HDR_DEFAULT
) (
    input  logic             clk,
    input  logic             ireset,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    input  logic             spi_ss_n,
    output logic             pm_we,
    output logic [PM_AW-1:0] pm_addr,
    output logic [15:0]      pm_din,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef PM_LOADER_CHKSUM_EN
    localparam ldr_state_e ST_END = ST_CHK;
`else
    localparam ldr_state_e ST_END = ST_DONE;
`endif

    logic       byte_vld;
    logic [7:0] byte_dat;
    logic       ss_fall;
    logic       ss_rise;
    logic       ss_n_lvl;

    ldr_state_e       state_q, state_d;
    logic [PM_AW-1:0] addr_q, addr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       lo_q, lo_d;
    logic [15:0]      din_q, din_d;
    logic             we_q, we_d;
    logic             inc_q, inc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rstn_q, rstn_d;
`ifdef PM_LOADER_CHKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif
    logic [15:0]      cnt_new;

    spi_byte_rx #(
        .SYNC_FF (SYNC_FF)
    ) u_rx (
        .clk      (clk),
        .ireset   (ireset),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_ss_n (spi_ss_n),
        .byte_vld (byte_vld),
        .byte_dat (byte_dat),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .ss_n_lvl (ss_n_lvl)
    );

    // Next-state logic: frame parsing, word writes and status flags
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        din_d   = din_q;
        we_d    = 1'b0;
        inc_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        rstn_d  = rstn_q;
`ifdef PM_LOADER_CHKSUM_EN
        chk_d   = chk_q;
`endif
        cnt_new = {byte_dat, cnt_q[7:0]};

        // Address advances the cycle after the write pulse
        if (inc_q) begin
            addr_d = addr_q + PM_AW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ss_fall) state_d = ST_HDR;
            end
            ST_DONE: begin
                if (ss_fall) begin
                    state_d = ST_HDR;
                end else if (ss_n_lvl) begin
                    rstn_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (ss_fall) begin
                    state_d = ST_HDR;
                end else if (ss_n_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Deselect mid-frame aborts, and beats a same-cycle byte
                if (ss_rise) begin
                    state_d = ST_ERR;
                end else if (byte_vld) begin
                    unique case (state_q)
                        ST_HDR: begin
                            state_d = (byte_dat == HDR_BYTE) ? ST_ADDR_L : ST_ERR;
                        end
                        ST_ADDR_L: begin
                            addr_d  = PM_AW'(byte_dat);
                            state_d = ST_ADDR_H;
                        end
                        ST_ADDR_H: begin
                            addr_d  = PM_AW'({byte_dat, addr_q[7:0]});
                            state_d = ST_CNT_L;
                        end
                        ST_CNT_L: begin
                            cnt_d   = {8'h00, byte_dat};
                            state_d = ST_CNT_H;
                        end
                        ST_CNT_H: begin
                            cnt_d   = cnt_new;
                            state_d = (cnt_new == 16'd0) ? ST_END : ST_DAT_L;
                        end
                        ST_DAT_L: begin
                            lo_d    = byte_dat;
`ifdef PM_LOADER_CHKSUM_EN
                            chk_d   = chk_fold(chk_q, byte_dat);
`endif
                            state_d = ST_DAT_H;
                        end
                        ST_DAT_H: begin
                            din_d   = {byte_dat, lo_q};
                            we_d    = 1'b1;
                            inc_d   = 1'b1;
                            cnt_d   = cnt_q - 16'd1;
`ifdef PM_LOADER_CHKSUM_EN
                            chk_d   = chk_fold(chk_q, byte_dat);
`endif
                            state_d = (cnt_q == 16'd1) ? ST_END : ST_DAT_L;
                        end
`ifdef PM_LOADER_CHKSUM_EN
                        ST_CHK: begin
                            state_d = (byte_dat == chk_q) ? ST_DONE : ST_ERR;
                        end
`endif
                        default: state_d = ST_ERR;
                    endcase
                end
            end
        endcase

        // Entry actions for the states that change status flags
        if (state_d != state_q) begin
            if (state_d == ST_HDR) begin
                done_d = 1'b0;
                err_d  = 1'b0;
                busy_d = 1'b1;
                rstn_d = 1'b0;
`ifdef PM_LOADER_CHKSUM_EN
                chk_d  = 8'h00;
`endif
            end
            if (state_d == ST_ERR) begin
                err_d  = 1'b1;
                busy_d = 1'b0;
            end
            if (state_d == ST_DONE) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    // State, datapath and status registers
    always_ff @(posedge clk or negedge ireset) begin
        if (!ireset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= 16'd0;
            lo_q    <= 8'h00;
            din_q   <= 16'h0000;
            we_q    <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rstn_q  <= 1'b0;
`ifdef PM_LOADER_CHKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            din_q   <= din_d;
            we_q    <= we_d;
            inc_q   <= inc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rstn_q  <= rstn_d;
`ifdef PM_LOADER_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign pm_we      = we_q;
    assign pm_addr    = addr_q;
    assign pm_din     = din_q;
    assign core_rst_n = rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pm_spi_loader.sv
// Scoreboard bench for pm_spi_loader: drives SPI frames, pushes expected
// Program_Mem writes when data words are sent, pops them on pm_we.
`timescale 1ns/1ps
module tb_pm_spi_loader;

    localparam int PM_AW = 14;

    logic             clk = 1'b0;
    logic             ireset = 1'b0;
    logic             spi_sck = 1'b0;
    logic             spi_mosi = 1'b0;
    logic             spi_ss_n = 1'b1;
    logic             pm_we;
    logic [PM_AW-1:0] pm_addr;
    logic [15:0]      pm_din;
    logic             core_rst_n;
    logic             busy;
    logic             done;
    logic             err;

    typedef struct packed {
        logic [PM_AW-1:0] a;
        logic [15:0]      d;
    } wr_t;

    wr_t              sb_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [PM_AW-1:0] exp_addr;
    logic [7:0]       tb_chk;
    logic             we_prev = 1'b0;

    pm_spi_loader #(
        .PM_AW    (PM_AW),
        .SYNC_FF  (2),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .ireset     (ireset),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_ss_n   (spi_ss_n),
        .pm_we      (pm_we),
        .pm_addr    (pm_addr),
        .pm_din     (pm_din),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every pm_we must match the oldest expected write
    always @(negedge clk) begin
        if (pm_we) begin
            if (we_prev) check("we_width", 32'd1, 32'd0);
            if (sb_q.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(pm_addr), 32'(e.a));
                check("wr_din", 32'(pm_din), 32'(e.d));
            end
        end
        we_prev = pm_we;
    end

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #40 spi_sck = 1'b1;
            #40 spi_sck = 1'b0;
        end
    endtask

    task automatic ss_low();
        spi_ss_n = 1'b0;
        #80;
    endtask

    task automatic ss_high();
        #80 spi_ss_n = 1'b1;
        #200;
    endtask

    task automatic frame_hdr(input logic [15:0] addr, input logic [15:0] cnt);
        ss_low();
        spi_byte(8'hA5);
        spi_byte(addr[7:0]);
        spi_byte(addr[15:8]);
        spi_byte(cnt[7:0]);
        spi_byte(cnt[15:8]);
        exp_addr = addr[PM_AW-1:0];
        tb_chk   = 8'h00;
    endtask

    task automatic word(input logic [15:0] w);
        spi_byte(w[7:0]);
        tb_chk = tb_chk ^ w[7:0];
        sb_q.push_back({exp_addr, w});
        spi_byte(w[15:8]);
        tb_chk = tb_chk ^ w[15:8];
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic frame_tail();
`ifdef PM_LOADER_CHKSUM_EN
        spi_byte(tb_chk);
`endif
        #80;
    endtask

    task automatic status(input string tag, input logic b, input logic d,
                          input logic e, input logic r);
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_err"}, 32'(err), 32'(e));
        check({tag, "_rstn"}, 32'(core_rst_n), 32'(r));
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_we"}, 32'(pm_we), 32'd0);
        check({tag, "_addr"}, 32'(pm_addr), 32'd0);
        check({tag, "_din"}, 32'(pm_din), 32'd0);
        status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        reset_vals("rst");
        repeat (3) @(posedge clk);
        #1 ireset = 1'b1;
        #100;
        reset_vals("rst_rel");

        // Basic two-word frame
        frame_hdr(16'h0100, 16'd2);
        check("t1_busy_mid", 32'(busy), 32'd1);
        word(16'h1234);
        word(16'h5678);
        check("t1_chk_val", 32'(tb_chk), 32'h08);
        frame_tail();
        status("t1_end", 1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_sb", 32'(sb_q.size()), 32'd0);
        ss_high();
        status("t1_rel", 1'b0, 1'b1, 1'b0, 1'b1);

        // Bad header, then a good frame
        ss_low();
        spi_byte(8'h5A);
        #80;
        status("t2_bad", 1'b0, 1'b0, 1'b1, 1'b0);
        ss_high();
        check("t2_rstn_hi", 32'(core_rst_n), 32'd0);
        frame_hdr(16'h0200, 16'd1);
        word(16'hC0DE);
        frame_tail();
        ss_high();
        status("t2_good", 1'b0, 1'b1, 1'b0, 1'b1);
        check("t2_sb", 32'(sb_q.size()), 32'd0);

        // Address wrap at the top of Program_Mem
        frame_hdr(16'h3FFF, 16'd2);
        word(16'h1111);
        word(16'h2222);
        frame_tail();
        ss_high();
        status("t3_wrap", 1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_addr", 32'(pm_addr), 32'h0001);
        check("t3_sb", 32'(sb_q.size()), 32'd0);

        // Deselect after the first of three words
        frame_hdr(16'h0010, 16'd3);
        word(16'hAAAA);
        ss_high();
        status("t4_abort", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_sb", 32'(sb_q.size()), 32'd0);

`ifdef PM_LOADER_CHKSUM_EN
        // Wrong checksum: words land, frame fails
        frame_hdr(16'h0020, 16'd2);
        word(16'h1234);
        word(16'h5678);
        spi_byte(8'h00);
        #80;
        status("t5_badchk", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_sb", 32'(sb_q.size()), 32'd0);
        ss_high();
`endif

        // Reset pulsed during the first DAT_L byte
        frame_hdr(16'h0030, 16'd2);
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b1;
            #40 spi_sck = 1'b1;
            #40 spi_sck = 1'b0;
        end
        ireset = 1'b0;
        #2;
        reset_vals("t6_inrst");
        #50;
        spi_ss_n = 1'b1;
        spi_sck  = 1'b0;
        #100 ireset = 1'b1;
        #100;
        reset_vals("t6_after");
        frame_hdr(16'h0040, 16'd2);
        word(16'hBEEF);
        word(16'hF00D);
        frame_tail();
        ss_high();
        status("t6_load", 1'b0, 1'b1, 1'b0, 1'b1);
        check("t6_addr", 32'(pm_addr), 32'h0042);
        check("t6_sb", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
